uart_tx_periph: RTL

- Memory-mapped UART transmitter on the RV32I data bus, at 0x4000_03xx.
- Sits directly downstream of the address decoder. It is selected by a new sel[4] line, and its rdata feeds a new read-mux input for 0x4000_03xx.
- Core writes bytes into an 8-deep TX FIFO; an 8N1 serialiser drains the FIFO onto the tx pin.
- Same bus interface as the GPO/GPI/GPIO peripherals (cs, wr, addr, wdata, rdata).

---
 rtl/uart_tx_periph_if.sv | 12 +
 rtl/uart_tx_periph.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_periph_if.sv
// Bus bundle for uart_tx_periph: decoder select, write strobe, address and data.
// The master drives the request side and the slave returns combinational read data.
interface uart_tx_periph_if;
    logic        cs;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output cs, wr, addr, wdata, input rdata);
    modport slave  (input cs, wr, addr, wdata, output rdata);
endinterface

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS/BAUDDIV at addr[3:2], TX FIFO feeding a serialiser.
// Define UART_TX_PARITY_EN to add a parity bit per frame and the STATUS[9] odd-parity select.
module uart_tx_periph #(
    parameter int FIFO_DEPTH   = 8,
    parameter int BAUD_DIV_RST = 868
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_periph_if.slave bus,
    output logic            tx
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    state_e      state_q, state_d;
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d, level;
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [7:0]  mem_d [FIFO_DEPTH];
    logic [15:0] baud_q, baud_d, div_q, div_d, cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d, head;
    logic        ovf_q, ovf_d, tx_q, tx_d;
    logic        full, empty, wr_en, push, pop, bit_end, stat_odd;
    logic [1:0]  sel;
    logic        unused_bits;
`ifdef UART_TX_PARITY_EN
    logic        odd_q, odd_d, par_q, par_d;
    assign stat_odd = odd_q;
`else
    assign stat_odd = 1'b0;
`endif

    assign sel         = bus.addr[3:2];
    assign wr_en       = bus.cs & bus.wr;
    assign level       = wptr_q - rptr_q;
    assign full        = (level == (AW+1)'(FIFO_DEPTH));
    assign empty       = (level == '0);
    assign push        = wr_en && (sel == 2'd0);
    assign pop         = (state_q == IDLE) && !empty;
    assign head        = mem_q[rptr_q[AW-1:0]];
    assign bit_end     = (cnt_q == div_q - 16'd1);
    assign tx          = tx_q;
    assign unused_bits = ^{bus.addr[31:4], bus.addr[1:0], bus.wdata[31:16]};

    // FIFO and register updates; a push while full is dropped even if a pop happens on the same edge
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        ovf_d  = ovf_q;
        baud_d = baud_q;
`ifdef UART_TX_PARITY_EN
        odd_d  = odd_q;
        if (wr_en && sel == 2'd1) odd_d = bus.wdata[9];
`endif
        if (push && !full) begin
            mem_d[wptr_q[AW-1:0]] = bus.wdata[7:0];
            wptr_d                = wptr_q + PTR_ONE;
        end
        if (pop) rptr_d = rptr_q + PTR_ONE;
        if (wr_en && sel == 2'd1 && bus.wdata[3]) ovf_d = 1'b0;
        if (push && full) ovf_d = 1'b1;
        if (wr_en && sel == 2'd2) baud_d = (bus.wdata[15:0] == '0) ? 16'd1 : bus.wdata[15:0];
    end

    always_ff @(posedge clk) mem_q <= mem_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            baud_q  <= 16'(BAUD_DIV_RST);
            div_q   <= 16'(BAUD_DIV_RST);
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            ovf_q   <= 1'b0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            odd_q   <= 1'b0;
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            baud_q  <= baud_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            ovf_q   <= ovf_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            odd_q   <= odd_d;
            par_q   <= par_d;
`endif
        end
    end

    // Divisor is latched at pop time so BAUDDIV writes only affect later frames
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        div_d   = div_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q != IDLE) cnt_d = bit_end ? '0 : cnt_q + 16'd1;
        case (state_q)
            IDLE: if (!empty) begin
                state_d = START;
                sh_d    = head;
                div_d   = baud_q;
                cnt_d   = '0;
                bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                par_d   = (^head) ^ odd_q;
`endif
            end
            START: if (bit_end) state_d = DATA;
            DATA: if (bit_end) begin
                if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end else begin
                    sh_d  = sh_q >> 1;
                    bit_d = bit_q + 3'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_end) state_d = STOP;
`endif
            STOP: if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // tx is registered from the next state so the pin lines up with state_q
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START: tx_d = 1'b0;
            DATA:  tx_d = sh_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.cs) begin
            case (sel)
                2'd1:    bus.rdata = {22'd0, stat_odd, 5'(level), ovf_q, empty, full, state_q != IDLE};
                2'd2:    bus.rdata = {16'd0, baud_q};
                default: bus.rdata = '0;
            endcase
        end
    end
endmodule
